// File: rtl/alu_seq_top_if.sv
// Request/result bus between a requester and the sequential ALU.
// The requester drives operands and opcode; the ALU returns ready, the registered results and the flags.
interface alu_seq_top_if #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ARITH_WIDTH = 2 * DATA_WIDTH
);
  logic signed [DATA_WIDTH-1:0]  A;
  logic signed [DATA_WIDTH-1:0]  B;
  logic [3:0]                    ALU_FUNC;
  logic                          IN_VALID;
  logic                          IN_READY;
  logic                          OUT_VALID;
  logic signed [ARITH_WIDTH-1:0] Arith_OUT;
  logic [DATA_WIDTH-1:0]         Logic_OUT;
  logic [1:0]                    CMP_OUT;
  logic [DATA_WIDTH:0]           SHIFT_OUT;
  logic                          Arith_Flag;
  logic                          Logic_Flag;
  logic                          CMP_Flag;
  logic                          SHIFT_Flag;
  logic                          ZERO_Flag;
  logic                          DIV_ERR;

  modport master (
    output A, B, ALU_FUNC, IN_VALID,
    input  IN_READY, OUT_VALID, Arith_OUT, Logic_OUT, CMP_OUT, SHIFT_OUT,
    input  Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag, ZERO_Flag, DIV_ERR
  );

  modport slave (
    input  A, B, ALU_FUNC, IN_VALID,
    output IN_READY, OUT_VALID, Arith_OUT, Logic_OUT, CMP_OUT, SHIFT_OUT,
    output Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag, ZERO_Flag, DIV_ERR
  );
endinterface

// File: rtl/alu_seq_top.sv
// Sequential ALU: single-cycle arith/logic/compare/shift units plus a
// restoring divider that produces one quotient bit per cycle.
module alu_seq_top #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ARITH_WIDTH = 2 * DATA_WIDTH
) (
  input logic         CLK,
  input logic         RST,
  alu_seq_top_if.slave bus
);
  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
  localparam int unsigned UW = ARITH_WIDTH - DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  state_t                        state_q;
  logic [DATA_WIDTH-1:0]         rem_q, quo_q, dvs_q;
  logic [CW-1:0]                 cnt_q;
  logic                          qneg_q, rneg_q;
  logic signed [ARITH_WIDTH-1:0] arith_q;
  logic [DATA_WIDTH-1:0]         logic_q;
  logic [1:0]                    cmp_q;
  logic [DATA_WIDTH:0]           shift_q;
  logic [3:0]                    flags_q;
  logic                          zero_q, err_q, valid_q;

  logic                          in_ready_c, transfer_c, is_div_c;
  logic signed [ARITH_WIDTH-1:0] ext_a, ext_b, nd_arith, div_res;
  logic [DATA_WIDTH-1:0]         nd_logic, abs_a, abs_b, rem_d, quo_d, quo_s, rem_s;
  logic [1:0]                    nd_cmp;
  logic [DATA_WIDTH:0]           nd_shift, rem_sh;
  logic [3:0]                    nd_flags;
  logic                          nd_zero, nd_err;

  // Ready is held low during reset so no transfer can be seen then.
  assign in_ready_c = RST && (state_q == S_IDLE);
  assign transfer_c = bus.IN_VALID && in_ready_c;
  assign is_div_c   = (bus.ALU_FUNC == 4'b0011);

  // Results of every op except an iterative divide, taken straight from the bus.
  always_comb begin
    ext_a    = ARITH_WIDTH'(bus.A);
    ext_b    = ARITH_WIDTH'(bus.B);
    nd_arith = '0;
    nd_logic = '0;
    nd_cmp   = '0;
    nd_shift = '0;
    nd_flags = '0;
    nd_err   = 1'b0;
    unique case (bus.ALU_FUNC[3:2])
      2'b00: begin
        nd_flags = 4'b0001;
        unique case (bus.ALU_FUNC[1:0])
          2'b00:   nd_arith = ext_a + ext_b;
          2'b01:   nd_arith = ext_a - ext_b;
          2'b10:   nd_arith = ext_a * ext_b;
          default: nd_err   = (bus.B == '0);
        endcase
      end
      2'b01: begin
        nd_flags = 4'b0010;
        unique case (bus.ALU_FUNC[1:0])
          2'b00:   nd_logic = bus.A & bus.B;
          2'b01:   nd_logic = bus.A | bus.B;
          2'b10:   nd_logic = ~(bus.A & bus.B);
          default: nd_logic = ~(bus.A | bus.B);
        endcase
      end
      2'b10: begin
        nd_flags = 4'b0100;
        unique case (bus.ALU_FUNC[1:0])
          2'b00:   nd_cmp = 2'd0;
          2'b01:   nd_cmp = (bus.A == bus.B) ? 2'd1 : 2'd0;
          2'b10:   nd_cmp = (bus.A > bus.B)  ? 2'd2 : 2'd0;
          default: nd_cmp = (bus.A < bus.B)  ? 2'd3 : 2'd0;
        endcase
      end
      default: begin
        nd_flags = 4'b1000;
        unique case (bus.ALU_FUNC[1:0])
          2'b00:   nd_shift = {1'b0, bus.A >> 1};
          2'b01:   nd_shift = {bus.A, 1'b0};
          2'b10:   nd_shift = {1'b0, DATA_WIDTH'(bus.B >>> 1)};
          default: nd_shift = {bus.B, 1'b0};
        endcase
      end
    endcase
    nd_zero = (nd_arith == '0) && (nd_logic == '0) && (nd_cmp == '0) && (nd_shift == '0);
  end

  // Restoring divider step on magnitudes; signs are reapplied on the final step.
  always_comb begin
    abs_a  = bus.A[DATA_WIDTH-1] ? DATA_WIDTH'(-bus.A) : DATA_WIDTH'(bus.A);
    abs_b  = bus.B[DATA_WIDTH-1] ? DATA_WIDTH'(-bus.B) : DATA_WIDTH'(bus.B);
    rem_sh = {rem_q, quo_q[DATA_WIDTH-1]};
    if (rem_sh >= {1'b0, dvs_q}) begin
      rem_d = DATA_WIDTH'(rem_sh - {1'b0, dvs_q});
      quo_d = {quo_q[DATA_WIDTH-2:0], 1'b1};
    end else begin
      rem_d = DATA_WIDTH'(rem_sh);
      quo_d = {quo_q[DATA_WIDTH-2:0], 1'b0};
    end
    quo_s   = qneg_q ? DATA_WIDTH'(-quo_d) : quo_d;
    rem_s   = rneg_q ? DATA_WIDTH'(-rem_d) : rem_d;
    div_res = {UW'($signed(rem_s)), quo_s};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      arith_q <= '0;
      logic_q <= '0;
      cmp_q   <= '0;
      shift_q <= '0;
      flags_q <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (transfer_c) begin
            if (is_div_c && (bus.B != '0)) begin
              state_q <= S_DIV;
              rem_q   <= '0;
              quo_q   <= abs_a;
              dvs_q   <= abs_b;
              cnt_q   <= '0;
              qneg_q  <= bus.A[DATA_WIDTH-1] ^ bus.B[DATA_WIDTH-1];
              rneg_q  <= bus.A[DATA_WIDTH-1];
            end else begin
              state_q <= S_DONE;
              arith_q <= nd_arith;
              logic_q <= nd_logic;
              cmp_q   <= nd_cmp;
              shift_q <= nd_shift;
              flags_q <= nd_flags;
              zero_q  <= nd_zero;
              err_q   <= nd_err;
              valid_q <= 1'b1;
            end
          end
        end
        S_DIV: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            state_q <= S_DONE;
            arith_q <= div_res;
            logic_q <= '0;
            cmp_q   <= '0;
            shift_q <= '0;
            flags_q <= 4'b0001;
            zero_q  <= (div_res == '0);
            err_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          flags_q <= '0;
          zero_q  <= 1'b0;
          err_q   <= 1'b0;
          valid_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.IN_READY   = in_ready_c;
  assign bus.OUT_VALID  = valid_q;
  assign bus.Arith_OUT  = arith_q;
  assign bus.Logic_OUT  = logic_q;
  assign bus.CMP_OUT    = cmp_q;
  assign bus.SHIFT_OUT  = shift_q;
  assign bus.Arith_Flag = flags_q[0];
  assign bus.Logic_Flag = flags_q[1];
  assign bus.CMP_Flag   = flags_q[2];
  assign bus.SHIFT_Flag = flags_q[3];
  assign bus.ZERO_Flag  = zero_q;
  assign bus.DIV_ERR    = err_q;
endmodule

// File: tb/tb_alu_seq_top.sv
// Directed bench for alu_seq_top at DATA_WIDTH=16 with hand-computed expectations.
module tb_alu_seq_top;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   lat;
  int   rdy_low;

  alu_seq_top_if bus ();

  alu_seq_top dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flags order: {SHIFT, CMP, Logic, Arith}.
  task automatic chk_out(input string tag, input logic [31:0] ea, input logic [15:0] el,
                         input logic [1:0] ec, input logic [16:0] es, input logic [3:0] ef,
                         input logic ez, input logic ee);
    chk({tag, ".valid"}, 64'(bus.OUT_VALID), 64'(1));
    chk({tag, ".arith"}, 64'($unsigned(bus.Arith_OUT)), 64'(ea));
    chk({tag, ".logic"}, 64'(bus.Logic_OUT), 64'(el));
    chk({tag, ".cmp"},   64'(bus.CMP_OUT), 64'(ec));
    chk({tag, ".shift"}, 64'(bus.SHIFT_OUT), 64'(es));
    chk({tag, ".flags"}, 64'({bus.SHIFT_Flag, bus.CMP_Flag, bus.Logic_Flag, bus.Arith_Flag}), 64'(ef));
    chk({tag, ".zero"},  64'(bus.ZERO_Flag), 64'(ez));
    chk({tag, ".err"},   64'(bus.DIV_ERR), 64'(ee));
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.ALU_FUNC = f;
    bus.IN_VALID = 1'b1;
    @(posedge clk);
    #1;
    bus.IN_VALID = 1'b0;
  endtask

  task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic [3:0] f, input int exp_lat);
    int n;
    n = 0;
    send(a, b, f);
    do begin
      @(negedge clk);
      n++;
    end while (bus.OUT_VALID !== 1'b1 && n < 40);
    chk({tag, ".lat"}, 64'(n), 64'(exp_lat));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.ALU_FUNC = '0;
    bus.IN_VALID = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.ready", 64'(bus.IN_READY), 64'(0));
    chk("rst.valid", 64'(bus.OUT_VALID), 64'(0));
    chk("rst.arith", 64'($unsigned(bus.Arith_OUT)), 64'(0));
    chk("rst.zero",  64'(bus.ZERO_Flag), 64'(0));
    rst_n = 1'b1;
    #1;
    chk("rst.ready_after", 64'(bus.IN_READY), 64'(1));

    // Add with sign extension, then hold of results after the pulse
    run("add", 16'hFFFB, 16'h0003, 4'b0000, 1);
    chk_out("add", 32'hFFFF_FFFE, 16'h0, 2'd0, 17'h0, 4'b0001, 1'b0, 1'b0);
    chk("add.ready_done", 64'(bus.IN_READY), 64'(0));
    @(negedge clk);
    chk("add.valid_drop", 64'(bus.OUT_VALID), 64'(0));
    chk("add.flag_drop",  64'(bus.Arith_Flag), 64'(0));
    chk("add.hold",       64'($unsigned(bus.Arith_OUT)), 64'h0000_0000_FFFF_FFFE);
    chk("add.ready_idle", 64'(bus.IN_READY), 64'(1));

    run("mul", 16'hFED4, 16'h00C8, 4'b0010, 1);
    chk_out("mul", 32'hFFFF_15A0, 16'h0, 2'd0, 17'h0, 4'b0001, 1'b0, 1'b0);
    run("sub", 16'h000A, 16'h000A, 4'b0001, 1);
    chk_out("sub", 32'h0, 16'h0, 2'd0, 17'h0, 4'b0001, 1'b1, 1'b0);

    // Divide with ignored IN_VALID pulses while busy
    send(16'hFFF9, 16'h0002, 4'b0011);
    lat = 0;
    rdy_low = 0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.IN_READY === 1'b0) rdy_low++;
      if (lat == 3) begin
        bus.A = 16'h0001;
        bus.B = 16'h0001;
        bus.ALU_FUNC = 4'b0000;
        bus.IN_VALID = 1'b1;
      end
      if (lat == 8) bus.IN_VALID = 1'b0;
    end while (bus.OUT_VALID !== 1'b1 && lat < 40);
    chk("div.lat", 64'(lat), 64'(17));
    chk("div.ready_low", 64'(rdy_low), 64'(17));
    chk_out("div", 32'hFFFF_FFFD, 16'h0, 2'd0, 17'h0, 4'b0001, 1'b0, 1'b0);
    @(negedge clk);
    chk("div.valid_drop", 64'(bus.OUT_VALID), 64'(0));
    @(negedge clk);
    chk("div.no_extra", 64'(bus.OUT_VALID), 64'(0));

    run("div0", 16'h0005, 16'h0000, 4'b0011, 1);
    chk_out("div0", 32'h0, 16'h0, 2'd0, 17'h0, 4'b0001, 1'b1, 1'b1);
    run("divmn", 16'h8000, 16'hFFFF, 4'b0011, 17);
    chk_out("divmn", 32'h0000_8000, 16'h0, 2'd0, 17'h0, 4'b0001, 1'b0, 1'b0);
    run("divpp", 16'd100, 16'd7, 4'b0011, 17);
    chk("divpp.arith", 64'($unsigned(bus.Arith_OUT)), 64'h0002_000E);
    run("divnp", 16'hFF9C, 16'd7, 4'b0011, 17);
    chk("divnp.arith", 64'($unsigned(bus.Arith_OUT)), 64'hFFFE_FFF2);
    run("divpn", 16'd100, 16'hFFF9, 4'b0011, 17);
    chk("divpn.arith", 64'($unsigned(bus.Arith_OUT)), 64'h0002_FFF2);

    run("or", 16'h00F0, 16'h0F00, 4'b0101, 1);
    chk_out("or", 32'h0, 16'h0FF0, 2'd0, 17'h0, 4'b0010, 1'b0, 1'b0);
    run("nand", 16'hF0F0, 16'h0FF0, 4'b0110, 1);
    chk("nand.logic", 64'(bus.Logic_OUT), 64'hFF0F);
    run("nor", 16'h0000, 16'h0000, 4'b0111, 1);
    chk("nor.logic", 64'(bus.Logic_OUT), 64'hFFFF);

    run("cmplt", 16'hFFFF, 16'h0001, 4'b1011, 1);
    chk_out("cmplt", 32'h0, 16'h0, 2'd3, 17'h0, 4'b0100, 1'b0, 1'b0);
    run("cmpeq", 16'h0007, 16'h0007, 4'b1001, 1);
    chk("cmpeq.cmp", 64'(bus.CMP_OUT), 64'(1));
    run("cmpgt", 16'hFFFF, 16'h0001, 4'b1010, 1);
    chk("cmpgt.cmp",  64'(bus.CMP_OUT), 64'(0));
    chk("cmpgt.zero", 64'(bus.ZERO_Flag), 64'(1));

    run("shl", 16'h8001, 16'h0000, 4'b1101, 1);
    chk_out("shl", 32'h0, 16'h0, 2'd0, 17'h1_0002, 4'b1000, 1'b0, 1'b0);
    run("shr", 16'h8001, 16'h0000, 4'b1100, 1);
    chk("shr.shift", 64'(bus.SHIFT_OUT), 64'h0_4000);
    run("sra", 16'h0000, 16'h8000, 4'b1110, 1);
    chk("sra.shift", 64'(bus.SHIFT_OUT), 64'h0_C000);
    run("shlb", 16'h0000, 16'h4001, 4'b1111, 1);
    chk("shlb.shift", 64'(bus.SHIFT_OUT), 64'h0_8002);

    // Reset during a divide, then an immediate transfer after release
    send(16'd1000, 16'd3, 4'b0011);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort.valid", 64'(bus.OUT_VALID), 64'(0));
    chk("abort.ready", 64'(bus.IN_READY), 64'(0));
    chk("abort.arith", 64'($unsigned(bus.Arith_OUT)), 64'(0));
    chk("abort.flags", 64'({bus.SHIFT_Flag, bus.CMP_Flag, bus.Logic_Flag, bus.Arith_Flag}), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bus.A = 16'hF0F0;
    bus.B = 16'h0FF0;
    bus.ALU_FUNC = 4'b0100;
    bus.IN_VALID = 1'b1;
    #1;
    chk("post.ready", 64'(bus.IN_READY), 64'(1));
    @(posedge clk);
    #1;
    bus.IN_VALID = 1'b0;
    @(negedge clk);
    chk_out("post", 32'h0, 16'h00F0, 2'd0, 17'h0, 4'b0010, 1'b0, 1'b0);
    @(negedge clk);
    chk("post.valid_drop", 64'(bus.OUT_VALID), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
